// File: rtl/song_sequencer_pkg.sv
// Shared types and constants for the song sequencer and its note player.
package song_sequencer_pkg;

    localparam int SONG_SEL_W = 2;   // 4 songs
    localparam int IDX_W      = 5;   // 32 entries per song
    localparam int NOTE_W     = 6;   // frequency ROM address
    localparam int DUR_W      = 6;   // duration in 1/48 s beats
    localparam int ADDR_W     = SONG_SEL_W + IDX_W;
    localparam int WORD_W     = NOTE_W + DUR_W;

    // A zero duration terminates a song early.
    localparam logic [DUR_W-1:0] END_MARKER = '0;
    localparam logic [IDX_W-1:0] LAST_IDX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LOAD,
        S_WAIT,
        S_DONE
    } state_e;

endpackage

// File: rtl/song_sequencer_rom.sv
// Song table: address {song, idx}, data {note, dur}, one-cycle registered read.
module song_sequencer_rom
    import song_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] dout
);

    // Songs 0-2 are short hand-written tunes ending in a zero duration;
    // song 3 fills all 32 slots so the sequencer has to stop on the index.
    function automatic logic [WORD_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        logic [IDX_W-1:0] i;
        i        = a[IDX_W-1:0];
        rom_word = '0;
        case (a[ADDR_W-1:IDX_W])
            2'd0: case (i)
                5'd0:    rom_word = {6'd37, 6'd12};
                5'd1:    rom_word = {6'd20, 6'd6};
                5'd2:    rom_word = {6'd15, 6'd9};
                5'd3:    rom_word = {6'd44, 6'd3};
                default: ;
            endcase
            2'd1: case (i)
                5'd0:    rom_word = {6'd10, 6'd4};
                5'd1:    rom_word = {6'd11, 6'd5};
                5'd2:    rom_word = {6'd12, 6'd6};
                default: ;
            endcase
            2'd2: case (i)
                5'd0:    rom_word = {6'd50, 6'd7};
                5'd1:    rom_word = {6'd51, 6'd8};
                default: ;
            endcase
            default: rom_word = {{i, 1'b1}, {1'b0, i} + 6'd1};
        endcase
    endfunction

    // Registered read port.
    always_ff @(posedge clk) begin
        dout <= rom_word(addr);
    end

endmodule

// File: rtl/song_sequencer.sv
// Walks the selected song in ROM, hands each note to the player with a
// one-cycle load pulse, waits for the player's done edge, flags end of song.
module song_sequencer
    import song_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  play,
    input  logic [SONG_SEL_W-1:0] song,
    input  logic                  note_done,
    output logic [NOTE_W-1:0]     note_to_load,
    output logic [DUR_W-1:0]      duration_to_load,
    output logic                  load_new_note,
    output logic                  song_done
);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [SONG_SEL_W-1:0] song_q, song_d;
    logic [NOTE_W-1:0]     note_q, note_d;
    logic [DUR_W-1:0]      dur_q, dur_d;
    logic                  load_q, load_d;
    logic                  done_q, done_d;
    logic                  nd_q, nd_d;

    logic [WORD_W-1:0]     rom_dout;
    logic [NOTE_W-1:0]     rom_note;
    logic [DUR_W-1:0]      rom_dur;
    logic                  nd_rise;

    song_sequencer_rom u_song_rom (
        .clk  (clk),
        .addr ({song_q, idx_q}),
        .dout (rom_dout)
    );

    assign rom_note = rom_dout[WORD_W-1:DUR_W];
    assign rom_dur  = rom_dout[DUR_W-1:0];
    // Edge reference freezes while paused, so a done that rises during a
    // pause is still seen as an edge once play returns.
    assign nd_rise  = note_done & ~nd_q;

    // Next-state, index, song latch and output register inputs.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        song_d  = song_q;
        note_d  = note_q;
        dur_d   = dur_q;
        load_d  = 1'b0;
        done_d  = 1'b0;
        nd_d    = play ? note_done : nd_q;

        if (song != song_q) begin
            // A new selection restarts from entry 0, whatever we were doing.
            song_d  = song;
            idx_d   = '0;
            state_d = play ? S_ADDR : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (play) state_d = S_ADDR;
                S_ADDR: state_d = S_LOAD;
                S_LOAD: begin
                    if (rom_dur == END_MARKER) begin
                        state_d = S_DONE;
                    end else begin
                        note_d  = rom_note;
                        dur_d   = rom_dur;
                        load_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (play && nd_rise) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = S_ADDR;
                        end
                    end
                end
                S_DONE: if (!play) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
            // Pulse song_done once on entry and rewind for the next play.
            if (state_d == S_DONE && state_q != S_DONE) begin
                done_d = 1'b1;
                idx_d  = '0;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            song_q  <= song;
            note_q  <= '0;
            dur_q   <= '0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
            nd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            song_q  <= song_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            load_q  <= load_d;
            done_q  <= done_d;
            nd_q    <= nd_d;
        end
    end

    assign note_to_load     = note_q;
    assign duration_to_load = dur_q;
    assign load_new_note    = load_q;
    assign song_done        = done_q;

endmodule
